// File: rtl/ppu_writer_pkg.sv
// Shared types and VGA timing constants for the PPU write-queue block.
package ppu_writer_pkg;

  localparam int HACTIVE = 1280;
  localparam int HTOTAL  = 1600;
  localparam int VACTIVE = 480;
  localparam int VTOTAL  = 525;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } ppu_wr_t;

  typedef enum logic [1:0] {S_WAIT, S_ISSUE, S_GAP} state_t;

endpackage

// File: rtl/ppu_writer_sync_fifo.sv
// Single-clock FIFO of PPU writes; pop data is registered and appears the cycle after pop.
module ppu_writer_sync_fifo
  import ppu_writer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  ppu_wr_t                  push_data,
  input  logic                     pop,
  input  logic                     flush,
  output ppu_wr_t                  pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  ppu_wr_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pop_data <= '0;
    end else begin
      // a pop on a flush cycle still delivers its entry downstream
      if (do_pop) pop_data <= mem[rd_ptr];
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({do_push, do_pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ppu_writer.sv
// Queues PPU table writes and replays them only inside vertical blank (or always, in bypass).
module ppu_writer
  import ppu_writer_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int GAP       = 0,
  parameter int VBL_START = 480,
  parameter int VBL_LAST  = 524,
  parameter int CUTOFF_H  = 1280
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [15:0]              push_addr,
  input  logic [31:0]              push_data,
  input  logic                     bypass,
  input  logic                     flush,
  input  logic [10:0]              hcount,
  input  logic [9:0]               vcount,
  output logic                     chipselect,
  output logic                     write,
  output logic [15:0]              address,
  output logic [31:0]              writedata,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     busy,
  output logic                     overflow
);

  localparam int          PW     = $clog2(DEPTH) + 1;
  localparam logic [9:0]  VS     = 10'(VBL_START);
  localparam logic [9:0]  VL     = 10'(VBL_LAST);
  localparam logic [10:0] CH     = 11'(CUTOFF_H);
  localparam logic [15:0] GAP_LD = (GAP > 0) ? 16'(GAP - 1) : 16'd0;

  state_t      state, state_nx;
  ppu_wr_t     head, push_ent;
  logic        full, empty, win, pop, more, stb_q;
  logic [15:0] gap_cnt;

  assign push_ent = '{addr: push_addr, data: push_data};

  ppu_writer_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .push      (push_valid),
    .push_data (push_ent),
    .pop       (pop),
    .flush     (flush),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (pending)
  );

  assign win = bypass
            || (vcount >= VS && vcount < VL)
            || (vcount == VL && hcount < CH);

  assign push_ready = reset_n && !full;

  // whether anything is left to issue once this cycle's pop has happened
  assign more = pop ? (pending != PW'(1)) : !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_WAIT;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_WAIT:  if (win && !empty && !flush) state_nx = S_ISSUE;
      S_ISSUE: begin
        if (pop && GAP > 0)              state_nx = S_GAP;
        else if (win && more && !flush)  state_nx = S_ISSUE;
        else                             state_nx = S_WAIT;
      end
      S_GAP:   if (gap_cnt == '0) state_nx = (win && !empty && !flush) ? S_ISSUE : S_WAIT;
      default: state_nx = S_WAIT;
    endcase
  end

  // pop is gated by the live window so a closing window never loses an entry
  always_comb begin
    pop  = (state == S_ISSUE) && win && !empty;
    busy = (state != S_WAIT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stb_q    <= 1'b0;
      gap_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      stb_q <= pop;
      if (pop)                                    gap_cnt <= GAP_LD;
      else if (state == S_GAP && gap_cnt != '0)   gap_cnt <= gap_cnt - 16'd1;
      if (flush)                                  overflow <= 1'b0;
      else if (push_valid && !push_ready)         overflow <= 1'b1;
    end
  end

  assign chipselect = stb_q;
  assign write      = stb_q;
  assign address    = head.addr;
  assign writedata  = head.data;

endmodule
